// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern sequencer: debounces two active-low push-buttons, keeps a
// mode/run register and steps the selected pattern at a prescaled rate.
module led_pattern_ctrl #(
    parameter int STEP_DIV        = 12500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s1_n,
    input  logic       s2_n,
    output logic [3:0] led_n,
    output logic [1:0] mode,
    output logic       running
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BINARY = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is s1, index 1 is s2.
    logic [1:0]            meta;
    logic [1:0]            sync;
    logic [1:0]            db;
    logic [1:0]            db_d;
    logic [1:0][CNT_W-1:0] db_cnt;
    logic [1:0]            press;

    mode_t            mode_q, mode_nx;
    logic             run_nx;
    logic [3:0]       pat, pat_nx;
    logic             dir_down, dir_nx;
    logic [CNT_W-1:0] presc, presc_nx;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 2'b11;
            sync   <= 2'b11;
            db     <= 2'b11;
            db_d   <= 2'b11;
            db_cnt <= '0;
        end else begin
            meta <= {s2_n, s1_n};
            sync <= meta;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEB_LAST) begin
                    db[i]     <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press is the cycle after the debounced level falls; releases are ignored.
    assign press = db_d & ~db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_CHASE;
            running  <= 1'b1;
            pat      <= 4'b0001;
            dir_down <= 1'b0;
            presc    <= '0;
        end else begin
            mode_q   <= mode_nx;
            running  <= run_nx;
            pat      <= pat_nx;
            dir_down <= dir_nx;
            presc    <= presc_nx;
        end
    end

    always_comb begin
        mode_nx  = mode_q;
        run_nx   = running;
        pat_nx   = pat;
        dir_nx   = dir_down;
        presc_nx = presc;
        tick     = running && (mode_q != MODE_OFF) && (presc == STEP_LAST);

        if (running && (mode_q != MODE_OFF)) begin
            presc_nx = tick ? '0 : presc + 1'b1;
        end

        if (tick) begin
            case (mode_q)
                MODE_CHASE: pat_nx = {pat[2:0], pat[3]};
                MODE_BOUNCE: begin
                    if (!dir_down) begin
                        pat_nx = pat << 1;
                        if (pat_nx == 4'b1000) dir_nx = 1'b1;
                    end else begin
                        pat_nx = pat >> 1;
                        if (pat_nx == 4'b0001) dir_nx = 1'b0;
                    end
                end
                MODE_BINARY: pat_nx = pat + 4'd1;
                default:     pat_nx = 4'b0000;
            endcase
        end

        if (press[1]) begin
            run_nx = ~running;
        end

        // A mode change overrides any step computed above in the same cycle.
        if (press[0]) begin
            mode_nx  = mode_t'(mode_q + 2'd1);
            presc_nx = '0;
            dir_nx   = 1'b0;
            case (mode_nx)
                MODE_CHASE, MODE_BOUNCE: pat_nx = 4'b0001;
                default:                 pat_nx = 4'b0000;
            endcase
        end
    end

    assign mode  = mode_q;
    assign led_n = ~pat;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: every change of {mode, running, led_n}
// is popped against a queue of expected states and edge distances.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s1_n;
    logic       s2_n;
    logic [3:0] led_n;
    logic [1:0] mode;
    logic       running;

    led_pattern_ctrl #(
        .STEP_DIV       (4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s1_n   (s1_n),
        .s2_n   (s2_n),
        .led_n  (led_n),
        .mode   (mode),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] val;
        int         gmin;
        int         gmax;
        string      nm;
    } exp_t;

    localparam logic [6:0] RST_OUT = {2'd1, 1'b1, 4'b1110};

    exp_t       q[$];
    int         n_total = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;
    int         arm_seq = 0;
    int         arm_seen = 0;
    int         mon_gap = 0;
    logic [6:0] mon_prev = RST_OUT;
    int         cur = 0;

    function automatic string fmt(input logic [6:0] v);
        return $sformatf("mode=%0d run=%0b led_n=%4b", v[6:5], v[4], v[3:0]);
    endfunction

    task automatic check(input bit ok, input string nm, input string act, input string req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", nm, act, req);
    endtask

    task automatic push(input logic [1:0] m, input logic r, input logic [3:0] l,
                        input int gmin, input int gmax, input string nm);
        exp_t e;
        e.val  = {m, r, l};
        e.gmin = gmin;
        e.gmax = gmax;
        e.nm   = nm;
        q.push_back(e);
    endtask

    // CHASE steps 1..n after a reset, one every 4 edges.
    task automatic push_chase(input int n, input string nm);
        logic [3:0] tbl [4];
        tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 1; k <= n; k++) push(2'd1, 1'b1, tbl[k % 4], 4, 4, nm);
    endtask

    // Advance to the falling clock edge following rising edge e of the section.
    task automatic go(input int e);
        while (cur < e) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic reset_pulse(input logic s1_hold);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        s1_n   = s1_hold;
        s2_n   = 1'b1;
        #1;
        check({mode, running, led_n} === RST_OUT, "async_reset",
              fmt({mode, running, led_n}), fmt(RST_OUT));
        @(negedge clk);
        rst_n = 1'b1;
        arm_seq++;
        mon_en = 1'b1;
        cur = 0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3 && q.size() != 0; i++) begin
            @(negedge clk);
            cur++;
        end
        check(q.size() == 0, nm, $sformatf("%0d pending", q.size()), "0 pending");
        q.delete();
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        logic [6:0] obs;
        exp_t       e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (arm_seen != arm_seq) begin
                    arm_seen = arm_seq;
                    mon_prev = RST_OUT;
                    mon_gap  = 0;
                end
                mon_gap++;
                obs = {mode, running, led_n};
                if (obs !== mon_prev) begin
                    check(q.size() != 0, "unexpected_change", fmt(obs), "no change");
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check(obs === e.val, e.nm, fmt(obs), fmt(e.val));
                        check(mon_gap >= e.gmin && mon_gap <= e.gmax, {e.nm, "_gap"},
                              $sformatf("%0d edges", mon_gap),
                              $sformatf("%0d..%0d edges", e.gmin, e.gmax));
                    end
                    mon_prev = obs;
                    mon_gap  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s1_n  = 1'b1;
        s2_n  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({mode, running, led_n} === RST_OUT, "power_on_reset",
              fmt({mode, running, led_n}), fmt(RST_OUT));

        // Free-running CHASE, then one clean s1 press into BOUNCE.
        reset_pulse(1'b1);
        push_chase(4, "chase_step");
        push(2'd2, 1'b1, 4'b1110, 1, 3, "s1_to_bounce");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b0111, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b1110, 4, 4, "bounce_step");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "bounce_step");
        go(7);  s1_n = 1'b0;
        go(15);
        check(mode == 2'd1 && running == 1'b1, "chase_mode_before_press",
              fmt({mode, running, led_n}), "mode=1 run=1");
        go(27); s1_n = 1'b1;
        go(46);
        drain("drain_press");

        // Short glitches only: pattern keeps chasing, no mode change.
        reset_pulse(1'b1);
        push_chase(14, "glitch_chase");
        for (int i = 0; i < 7; i++) begin
            go(1 + 6 * i); s1_n = 1'b0;
            go(4 + 6 * i); s1_n = 1'b1;
        end
        go(56);
        drain("drain_glitch");

        // Same glitch burst ending in a stable low: exactly one advance.
        reset_pulse(1'b1);
        push_chase(13, "burst_chase");
        push(2'd2, 1'b1, 4'b1110, 1, 3, "burst_then_press");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "burst_bounce");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "burst_bounce");
        push(2'd2, 1'b1, 4'b0111, 4, 4, "burst_bounce");
        for (int i = 0; i < 7; i++) begin
            go(1 + 6 * i); s1_n = 1'b0;
            go(4 + 6 * i); s1_n = 1'b1;
        end
        go(43); s1_n = 1'b0;
        go(53); s1_n = 1'b1;
        go(66);
        drain("drain_burst");

        // CHASE -> BOUNCE -> BINARY (full count with wrap) -> OFF.
        reset_pulse(1'b1);
        push_chase(3, "mode_chase");
        push(2'd2, 1'b1, 4'b1110, 1, 3, "to_bounce");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "mode_bounce");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "mode_bounce");
        push(2'd2, 1'b1, 4'b0111, 4, 4, "mode_bounce");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "mode_bounce");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "mode_bounce");
        push(2'd3, 1'b1, 4'b1111, 1, 3, "to_binary");
        for (int j = 0; j < 17; j++) begin
            logic [3:0] p;
            p = 4'(j + 1);
            push(2'd3, 1'b1, ~p, 4, 4, "binary_step");
        end
        push(2'd0, 1'b1, 4'b1111, 1, 3, "to_off");
        go(3);   s1_n = 1'b0;
        go(15);  s1_n = 1'b1;
        go(25);  s1_n = 1'b0;
        go(37);  s1_n = 1'b1;
        go(95);  s1_n = 1'b0;
        go(107); s1_n = 1'b1;
        go(156);
        check(mode == 2'd0 && led_n == 4'b1111, "off_held",
              fmt({mode, running, led_n}), "mode=0 led_n=1111");
        drain("drain_modes");

        // s2 pause at 1011, frozen, then resume from the held prescaler.
        reset_pulse(1'b1);
        push_chase(6, "pause_chase");
        push(2'd1, 1'b0, 4'b1011, 1, 3, "s2_pause");
        push(2'd1, 1'b1, 4'b1011, 39, 41, "s2_resume");
        push(2'd1, 1'b1, 4'b0111, 2, 2, "resume_step");
        push(2'd1, 1'b1, 4'b1110, 4, 4, "resume_step");
        go(15); s2_n = 1'b0;
        go(27); s2_n = 1'b1;
        go(40);
        check(running == 1'b0 && led_n == 4'b1011, "paused_frozen",
              fmt({mode, running, led_n}), "run=0 led_n=1011");
        go(55); s2_n = 1'b0;
        go(67); s2_n = 1'b1;
        go(72);
        drain("drain_pause");

        // s1 press landing on a tick, then reset mid-BOUNCE during a bounce.
        reset_pulse(1'b1);
        push_chase(2, "tick_chase");
        push(2'd2, 1'b1, 4'b1110, 3, 5, "press_on_tick");
        push(2'd2, 1'b1, 4'b1101, 4, 4, "after_tick_bounce");
        push(2'd2, 1'b1, 4'b1011, 4, 4, "after_tick_bounce");
        push(2'd2, 1'b1, 4'b0111, 4, 4, "after_tick_bounce");
        go(1);  s1_n = 1'b0;
        go(11); s1_n = 1'b1;
        go(21); s1_n = 1'b0;
        go(25);
        drain("drain_tick");
        reset_pulse(1'b0);
        push_chase(5, "post_reset_chase");
        go(6);  s1_n = 1'b1;
        go(20);
        check(mode == 2'd1 && running == 1'b1, "bounce_discarded",
              fmt({mode, running, led_n}), "mode=1 run=1");
        drain("drain_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
